// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM states and decode helpers for the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    return sz == 2'd0 ? 8'h01 : sz == 2'd1 ? 8'h03 : sz == 2'd2 ? 8'h0F : 8'hFF;
  endfunction
  function automatic logic is_fault(input logic we, input logic [2:0] f3, input logic [2:0] lo, input logic x64);
    logic illegal, mis;
    illegal = we ? (f3[2] || (f3 == F3_D && !x64))
                 : (f3 == 3'b111 || ((f3 == F3_D || f3 == F3_WU) && !x64));
    mis = f3[1:0] == 2'd1 ? lo[0] : f3[1:0] == 2'd2 ? |lo[1:0] : f3[1:0] == 2'd3 ? |lo : 1'b0;
    return illegal | mis;
  endfunction
endpackage

// File: rtl/lsu_pipelined_load_align.sv
// lsu_load_align: shifts the addressed lane down and sign/zero-extends from the access width
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int OW = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [OW-1:0]   off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);
  logic [XLEN-1:0] sh, m;
  logic msb;
  always_comb begin
    sh = rdata >> {off, 3'b000};
    m = {XLEN{1'b1}} << (32'd8 << funct3[1:0]);
    msb = funct3[1:0] == 2'd0 ? sh[7] : funct3[1:0] == 2'd1 ? sh[15] : sh[31];
    result = (sh & ~m) | ({XLEN{msb & ~funct3[2]}} & m);
  end
endmodule

// File: rtl/lsu_pipelined.sv
// lsu_pipelined: single-outstanding load/store unit driving a synchronous single-port RAM
module lsu_pipelined
  import lsu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ADDR_W = 32,
  parameter int MEM_LATENCY = 1,
  localparam int NB = XLEN / 8,
  localparam int OW = $clog2(NB)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]  req_wdata,
  output logic             resp_valid,
  output logic [XLEN-1:0]  resp_rdata,
  output logic             resp_fault,
  output logic             mem_en,
  output logic             mem_we,
  output logic [NB-1:0]    mem_be,
  output logic [ADDR_W-OW-1:0] mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic [XLEN-1:0]  mem_rdata
);
  state_e state_q, state_d;
  logic we_q, we_d, fault_q, fault_d;
  logic [2:0] f3_q, f3_d;
  logic [1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d, rdata_q, rdata_d, ld_res;
  logic [OW-1:0] off;
  assign off = addr_q[OW-1:0];
  lsu_load_align #(.XLEN(XLEN)) u_align (
    .rdata(mem_rdata),
    .off(off),
    .funct3(f3_q),
    .result(ld_res)
  );
  always_comb begin
    state_d = state_q;
    we_d = we_q;
    f3_d = f3_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d = req_we;
        f3_d = req_funct3;
        addr_d = req_addr;
        wdata_d = req_wdata;
        fault_d = is_fault(req_we, req_funct3, req_addr[2:0], XLEN == 64);
        rdata_d = '0;
        cnt_d = '0;
        state_d = fault_d ? RESP : ISSUE;
      end
      ISSUE: state_d = we_q ? RESP : WAIT;
      WAIT: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'(MEM_LATENCY - 1)) begin
          rdata_d = ld_res;
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      f3_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      f3_q <= f3_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      cnt_q <= cnt_d;
    end
  assign req_ready = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_fault = resp_valid & fault_q;
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign mem_en = state_q == ISSUE;
  assign mem_we = mem_en & we_q;
  assign mem_be = mem_en ? NB'(size_mask(f3_q[1:0])) << off : '0;
  assign mem_addr = mem_en ? addr_q[ADDR_W-1:OW] : '0;
  assign mem_wdata = !mem_en ? '0
                   : f3_q[1:0] == 2'd0 ? {NB{wdata_q[7:0]}}
                   : f3_q[1:0] == 2'd1 ? {(NB/2){wdata_q[15:0]}}
                   : f3_q[1:0] == 2'd2 ? {(NB/4){wdata_q[31:0]}}
                   : wdata_q;
endmodule

// File: tb/tb_lsu_pipelined.sv
// tb_lsu_pipelined: scoreboard bench for a 32-bit/latency-1 and a 64-bit/latency-3 unit
module tb_lsu_pipelined;
  typedef struct { int d; logic [63:0] rdata; logic fault; int cyc; } resp_t;
  typedef struct { int d; logic we; logic [7:0] be; logic [31:0] addr; logic [63:0] wdata; } beat_t;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int cyc = 0, checks = 0, errors = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [1:0] rv = '0, rwe = '0, rdy, ovalid, ofault, men, mwe;
  logic [2:0] rf3[2];
  logic [31:0] raddr[2];
  logic [63:0] rwd[2], rdv[2], ordata[2], mwdata[2];
  logic [7:0] mbe[2];
  logic [31:0] maddr[2];
  logic [31:0] rdata0, wdata0, mrd0;
  logic [3:0] be0;
  logic [29:0] ma0;
  logic [63:0] rdata1, wdata1, mrd1;
  logic [7:0] be1;
  logic [28:0] ma1;
  logic p0 = 0;
  logic [2:0] p1 = '0;
  resp_t rq[$];
  beat_t bq[$];
  lsu_pipelined #(.XLEN(32), .ADDR_W(32), .MEM_LATENCY(1)) u32 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rdy[0]), .req_we(rwe[0]),
    .req_funct3(rf3[0]), .req_addr(raddr[0]), .req_wdata(rwd[0][31:0]),
    .resp_valid(ovalid[0]), .resp_rdata(rdata0), .resp_fault(ofault[0]),
    .mem_en(men[0]), .mem_we(mwe[0]), .mem_be(be0), .mem_addr(ma0),
    .mem_wdata(wdata0), .mem_rdata(mrd0)
  );
  lsu_pipelined #(.XLEN(64), .ADDR_W(32), .MEM_LATENCY(3)) u64 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rdy[1]), .req_we(rwe[1]),
    .req_funct3(rf3[1]), .req_addr(raddr[1]), .req_wdata(rwd[1]),
    .resp_valid(ovalid[1]), .resp_rdata(rdata1), .resp_fault(ofault[1]),
    .mem_en(men[1]), .mem_we(mwe[1]), .mem_be(be1), .mem_addr(ma1),
    .mem_wdata(wdata1), .mem_rdata(mrd1)
  );
  assign ordata[0] = {32'b0, rdata0};
  assign ordata[1] = rdata1;
  assign mwdata[0] = {32'b0, wdata0};
  assign mwdata[1] = wdata1;
  assign mbe[0] = {4'b0, be0};
  assign mbe[1] = be1;
  assign maddr[0] = {2'b0, ma0};
  assign maddr[1] = {3'b0, ma1};
  // RAM model: read data is only valid exactly MEM_LATENCY cycles after the read beat
  always @(posedge clk) begin
    p0 <= men[0] & ~mwe[0];
    p1 <= {p1[1:0], men[1] & ~mwe[1]};
  end
  assign mrd0 = p0 ? rdv[0][31:0] : 32'hDEADBEEF;
  assign mrd1 = p1[2] ? rdv[1] : 64'hDEADBEEF_DEADBEEF;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin : mon
    resp_t e;
    beat_t b;
    for (int d = 0; d < 2; d++) begin
      if (ovalid[d]) begin
        if (rq.size() == 0 || rq[0].d != d) chk("resp_unexpected", 1, 0);
        else begin
          e = rq.pop_front();
          chk("resp_rdata", ordata[d], e.rdata);
          chk("resp_fault", {63'b0, ofault[d]}, {63'b0, e.fault});
          chk("resp_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (men[d]) begin
        if (bq.size() == 0 || bq[0].d != d) chk("beat_unexpected", 1, 0);
        else begin
          b = bq.pop_front();
          chk("mem_we", {63'b0, mwe[d]}, {63'b0, b.we});
          chk("mem_be", {56'b0, mbe[d]}, {56'b0, b.be});
          chk("mem_addr", {32'b0, maddr[d]}, {32'b0, b.addr});
          chk("mem_wdata", mwdata[d], b.wdata);
        end
      end
    end
  end
  task automatic issue(input int d, input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [63:0] wd, input logic [63:0] rd, input logic [63:0] exp_rd,
                       input logic exp_f, input logic [7:0] exp_be, input logic [31:0] exp_ma,
                       input logic [63:0] exp_wd, input int lat);
    int acc;
    @(negedge clk);
    rv[d] = 1; rwe[d] = we; rf3[d] = f3; raddr[d] = a; rwd[d] = wd; rdv[d] = rd;
    @(posedge clk);
    #1;
    rv[d] = 0;
    acc = cyc;
    chk("ready_busy", {63'b0, rdy[d]}, 0);
    rq.push_back('{d, exp_rd, exp_f, acc + lat - 1});
    if (!exp_f) bq.push_back('{d, we, exp_be, exp_ma, exp_wd});
    for (int i = 0; i < 20 && rq.size() != 0; i++) @(negedge clk);
    chk("resp_timeout", 64'(rq.size()), 0);
    rq.delete();
    bq.delete();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 2; i++) begin rf3[i] = 0; raddr[i] = 0; rwd[i] = 0; rdv[i] = 0; end
    #12;
    chk("rst_ready", {62'b0, rdy}, 64'h3);
    chk("rst_resp_valid", {62'b0, ovalid}, 0);
    chk("rst_mem_en", {62'b0, men}, 0);
    chk("rst_mem_be", {56'b0, mbe[1]}, 0);
    chk("rst_mem_addr", {32'b0, maddr[0]}, 0);
    chk("rst_mem_wdata", mwdata[1], 0);
    chk("rst_resp_rdata", ordata[0], 0);
    @(negedge clk);
    rst = 0;
    issue(0, 1, 3'd0, 32'h103, 64'hA5, 0, 0, 0, 8'h8, 32'h40, 64'hA5A5A5A5, 2);
    issue(0, 0, 3'd0, 32'h101, 0, 64'h8000, 64'hFFFFFF80, 0, 8'h2, 32'h40, 0, 3);
    issue(0, 0, 3'd4, 32'h101, 0, 64'h8000, 64'h80, 0, 8'h2, 32'h40, 0, 3);
    issue(0, 0, 3'd1, 32'h102, 0, 64'h80010000, 64'hFFFF8001, 0, 8'hC, 32'h40, 0, 3);
    issue(0, 0, 3'd2, 32'h102, 0, 0, 0, 1, 0, 0, 0, 1);
    issue(0, 0, 3'd3, 32'h100, 0, 0, 0, 1, 0, 0, 0, 1);
    issue(0, 1, 3'd3, 32'h100, 0, 0, 0, 1, 0, 0, 0, 1);
    issue(0, 0, 3'd6, 32'h100, 0, 0, 0, 1, 0, 0, 0, 1);
    issue(0, 0, 3'd7, 32'h100, 0, 0, 0, 1, 0, 0, 0, 1);
    issue(0, 1, 3'd4, 32'h100, 0, 0, 0, 1, 0, 0, 0, 1);
    issue(0, 1, 3'd1, 32'h101, 64'h1234, 0, 0, 1, 0, 0, 0, 1);
    issue(0, 1, 3'd1, 32'h102, 64'h1234BEEF, 0, 0, 0, 8'hC, 32'h40, 64'hBEEFBEEF, 2);
    issue(0, 1, 3'd2, 32'h4, 64'hCAFEF00D, 0, 0, 0, 8'hF, 32'h1, 64'hCAFEF00D, 2);
    issue(0, 0, 3'd5, 32'h100, 0, 64'h0000F00F, 64'h0000F00F, 0, 8'h3, 32'h40, 0, 3);
    issue(0, 0, 3'd1, 32'h100, 0, 64'h0000F00F, 64'hFFFFF00F, 0, 8'h3, 32'h40, 0, 3);
    issue(1, 0, 3'd2, 32'h0, 0, 64'h12345678, 64'h12345678, 0, 8'h0F, 32'h0, 0, 5);
    issue(1, 1, 3'd3, 32'h8, 64'h1122334455667788, 0, 0, 0, 8'hFF, 32'h1, 64'h1122334455667788, 2);
    issue(1, 0, 3'd6, 32'h4, 0, 64'hF000000000000000, 64'h00000000F0000000, 0, 8'hF0, 32'h0, 0, 5);
    issue(1, 0, 3'd2, 32'h4, 0, 64'hF000000000000000, 64'hFFFFFFFFF0000000, 0, 8'hF0, 32'h0, 0, 5);
    issue(1, 0, 3'd3, 32'h4, 0, 0, 0, 1, 0, 0, 0, 1);
    issue(1, 0, 3'd3, 32'h10, 0, 64'h8877665544332211, 64'h8877665544332211, 0, 8'hFF, 32'h2, 0, 5);
    issue(1, 1, 3'd0, 32'h7, 64'h5A, 0, 0, 0, 8'h80, 32'h0, 64'h5A5A5A5A5A5A5A5A, 2);
    issue(1, 0, 3'd0, 32'h7, 0, 64'h7F00000000000000, 64'h7F, 0, 8'h80, 32'h0, 0, 5);
    issue(1, 0, 3'd1, 32'h6, 0, 64'h8000000000000000, 64'hFFFFFFFFFFFF8000, 0, 8'hC0, 32'h0, 0, 5);
    // reset while the 32-bit unit is mid-beat: mem_en must fall without a clock edge
    @(negedge clk);
    rv[0] = 1; rwe[0] = 1; rf3[0] = 3'd2; raddr[0] = 32'h8; rwd[0] = 64'h55;
    @(posedge clk);
    #1;
    rv[0] = 0;
    chk("issue_mem_en", {63'b0, men[0]}, 1);
    rst = 1;
    #1;
    chk("rst_async_mem_en", {63'b0, men[0]}, 0);
    @(negedge clk);
    rst = 0;
    // reset while the 64-bit unit waits on RAM data
    @(negedge clk);
    rv[1] = 1; rwe[1] = 0; rf3[1] = 3'd2; raddr[1] = 32'h0; rdv[1] = 64'h99;
    @(posedge clk);
    #1;
    rv[1] = 0;
    bq.push_back('{1, 1'b0, 8'h0F, 32'h0, 64'h0});
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    chk("rst_wait_mem_en", {63'b0, men[1]}, 0);
    chk("rst_wait_resp_valid", {63'b0, ovalid[1]}, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("ready_after_rst", {63'b0, rdy[1]}, 1);
    repeat (8) @(negedge clk);
    chk("beats_left", 64'(bq.size()), 0);
    chk("resps_left", 64'(rq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lsu_pipelined.md
Name: lsu_pipelined

Overview:
- Parametrised load/store unit between the core execute stage and a synchronous single-port data RAM.
- Accepts one request at a time over a valid/ready handshake and issues one memory beat with byte enables aligned to the address offset.
- Waits a configurable RAM read latency, then returns lane-extracted, sign- or zero-extended load data.
- Detects misaligned and illegal accesses and reports them as faults without touching memory.

Parameters:
- XLEN, 32, data width; 32 or 64 only. 64 enables LD/LWU/SD.
- ADDR_W, 32, byte-address width.
- MEM_LATENCY, 1, RAM read latency in cycles (1..4).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 of the load/store.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  XLEN  extended load data; 0 for stores and faults.
- resp_fault  out  1  misaligned or illegal funct3.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_be  out  XLEN/8  byte enables.
- mem_addr  out  ADDR_W-log2(XLEN/8)  word address.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_rdata  in  XLEN  RAM read data, valid MEM_LATENCY cycles after the mem_en cycle.

Behaviour:
- Reset is asynchronous and active-high; reset port is rst, clock is clk.
- On reset: state IDLE; req_ready=1; resp_valid, resp_fault, mem_en, mem_we=0; mem_be, mem_addr, mem_wdata, resp_rdata=0.
- Reset asserted mid-operation:
  - mem_en drops immediately (asynchronously).
  - The pending operation is discarded; no response is produced.
- States and transitions:
  - IDLE: req_ready=1. Accept when req_valid && req_ready. Register we, funct3, addr and wdata. Go to RESP if the request faults, else ISSUE.
  - ISSUE (1 cycle): mem_en=1, mem_we=we, with mem_be/mem_addr/mem_wdata decoded from registered fields. Store goes to RESP; load goes to WAIT.
  - WAIT: counter runs MEM_LATENCY cycles. In the last count cycle, capture the extended mem_rdata. Then go to RESP.
  - RESP (1 cycle): resp_valid=1. Go to IDLE.
  - req_ready=0 in every state except IDLE.
  - No response backpressure: the consumer must take resp_valid when it is asserted.
- Latency from the accept edge to resp_valid:
  - fault: 1 cycle.
  - store: 2 cycles.
  - load: MEM_LATENCY+2 cycles.
  - Minimum request spacing is latency+1 cycles.
- funct3 decode:
  - Loads: LB 000, LH 001, LW 010, LD 011, LBU 100, LHU 101, LWU 110.
  - Stores: SB 000, SH 001, SW 010, SD 011.
  - Illegal, reported as fault: load 111; store 1xx; 011/110 when XLEN=32.
- Misalignment (fault):
  - halfword: addr[0]!=0.
  - word: addr[1:0]!=0.
  - doubleword: addr[2:0]!=0.
- Byte lanes:
  - off = addr[log2(XLEN/8)-1:0].
  - mem_be = size mask (1/3/F/FF) << off.
  - mem_wdata = low byte/half/word replicated across all lanes.
- Load extract: shift mem_rdata right by off*8, then extend from the access width.
  - Signed loads replicate the access MSB (bit 7/15/31).
  - Unsigned loads zero-fill.
- Fault: no mem_en pulse; resp_rdata=0.
- Store response: resp_rdata=0, resp_fault=0.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams.
  - state enum IDLE/ISSUE/WAIT/RESP.
  - size-mask function.
  - fault-check function.
- Sub-module lsu_load_align: purely combinational. Inputs: rdata, off, funct3. Output: extended XLEN result. Instantiated once, feeding the WAIT capture register.

Test Plan:
1. XLEN=32, MEM_LATENCY=1. SB addr 0x103, wdata 0xA5 -> mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x40; resp_valid 2 cycles after accept, fault=0.
2. LB addr 0x101 with mem_rdata=0x0000_8000 -> resp_rdata=0xFFFFFF80. LBU at the same address -> 0x00000080. resp_valid 3 cycles after accept.
3. LH addr 0x102 with mem_rdata=0x8001_0000 -> 0xFFFF8001. LW addr 0x102 -> resp_fault=1 after 1 cycle, no mem_en pulse.
4. MEM_LATENCY=3, LW addr 0x0, mem_rdata=0x12345678 presented 3 cycles after mem_en -> resp_rdata=0x12345678, 5 cycles after accept. req_ready low throughout.
5. XLEN=64: SD addr 0x8 -> mem_be=0xFF. LWU addr 0x4 with mem_rdata upper word 0xF0000000 -> 0x00000000F0000000. XLEN=32 funct3=011 -> fault.
6. Assert rst during WAIT -> mem_en, resp_valid=0 immediately; no resp_valid after release; req_ready=1 on the first cycle after release.
